// File: rtl/store_buffer.sv
// store_buffer: small in-order FIFO of pending stores in front of a single
// byte-enabled memory write port. Drains the head entry whenever the port is
// free and flags loads that overlap any buffered store.
//
// Handshake: a store is accepted at a posedge when st_valid && st_ready.
// st_ready depends only on registered occupancy, never on st_valid or drain_en.
// A drain happens at a posedge when !empty && drain_en; mem_wr_en is the only
// qualifier, and mem_wr_addr/mem_wr_data are don't-care while it is 2'b00.

`ifndef ALEN
`define ALEN 16
`endif
`ifndef XLEN
`define XLEN 16
`endif

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [`ALEN-1:0]           st_addr,
    input  logic [`XLEN-1:0]           st_data,
    input  logic                       st_size,
    input  logic                       drain_en,
    output logic [`ALEN-1:0]           mem_wr_addr,
    output logic [`XLEN-1:0]           mem_wr_data,
    output logic [1:0]                 mem_wr_en,
    input  logic [`ALEN-1:0]           ld_addr,
    input  logic                       ld_size,
    output logic                       ld_hazard,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [`ALEN-1:0] addr_q [DEPTH];
    logic [`XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] size_q;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // True when any byte of a store overlaps any byte of the load; +1 wraps at the
    // address width so a word at the top of memory covers address 0.
    function automatic logic overlap(input logic [`ALEN-1:0] sa, input logic ss,
                                     input logic [`ALEN-1:0] la, input logic ls);
        logic [`ALEN-1:0] sa1, la1;
        sa1 = sa + `ALEN'(1);
        la1 = la + `ALEN'(1);
        return (sa == la) || (ss && (sa1 == la)) || (ls && (sa == la1)) ||
               (ss && ls && (sa1 == la1));
    endfunction

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign st_ready = (count_q != CW'(DEPTH));
    assign push     = st_valid && st_ready;
    assign pop      = !empty && drain_en;

    // Head entry is presented continuously; the enable alone qualifies the write.
    assign mem_wr_addr = addr_q[head_q];
    assign mem_wr_data = data_q[head_q];
    assign mem_wr_en   = pop ? (size_q[head_q] ? 2'b11 : 2'b01) : 2'b00;

    // Next-state for pointers, occupancy and per-slot valid bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (push) begin
            tail_d          = tail_q + PW'(1);
            valid_d[tail_q] = 1'b1;
        end
        if (pop) begin
            head_d          = head_q + PW'(1);
            valid_d[head_q] = 1'b0;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage; contents are meaningless unless the slot's valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            size_q[tail_q] <= st_size;
        end
    end

    // Hazard scan over every valid slot, including the head draining this cycle.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && overlap(addr_q[i], size_q[i], ld_addr, ld_size))
                ld_hazard = 1'b1;
        end
    end

endmodule
